// File: rtl/conv_window_scheduler.sv
// Raster-scan scheduler for a shared KxK convolution unit: walks the frame, strobes one load per full window, returns each result on a valid/ready stream.
// Optional build macro CONV_CLIP_U8_EN saturates each captured result to the unsigned 8-bit range 0..255.
module conv_window_scheduler #(
    parameter int KERNEL_SIZE  = 3,
    parameter int IMG_WIDTH    = 640,
    parameter int IMG_HEIGHT   = 480,
    parameter int CONV_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        conv_load,
    input  logic [31:0] conv_ans,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        frame_done
);

    localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int CW = $clog2(CONV_LATENCY + 1);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
    localparam logic [XW-1:0] X_EDGE = XW'(KERNEL_SIZE - 1);
    localparam logic [YW-1:0] Y_EDGE = YW'(KERNEL_SIZE - 1);
    localparam logic [CW-1:0] LAT    = CW'(CONV_LATENCY);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_LOAD   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_OUTPUT = 3'd4
    } state_t;

    // Saturate a signed 32-bit value to 0..255, zero-extended.
    function automatic logic [31:0] clip_u8(input logic [31:0] v);
        logic [31:0] r;
        if (v[31]) begin
            r = 32'd0;
        end else if (v[30:8] != 23'd0) begin
            r = 32'd255;
        end else begin
            r = {24'd0, v[7:0]};
        end
        return r;
    endfunction

    // Result conditioning applied at the capture edge.
    function automatic logic [31:0] post_process(input logic [31:0] v);
`ifdef CONV_CLIP_U8_EN
        return clip_u8(v);
`else
        return v;
`endif
    endfunction

    state_t          state_r, state_n;
    logic [XW-1:0]   x_r, x_n;
    logic [YW-1:0]   y_r, y_n;
    logic [CW-1:0]   wait_r, wait_n;
    logic            last_win_r, last_win_n;
    logic            cap_s;
    logic            done_s;
    logic            xfer_s;
    logic            hs_s;
    logic            corner_s;
    logic            corner_last_s;

    logic            pix_ready_r;
    logic            conv_load_r;
    logic            out_valid_r;
    logic [31:0]     out_data_r;
    logic            out_last_r;
    logic            busy_r;
    logic            frame_done_r;

    assign xfer_s        = pix_ready_r && pix_valid;
    assign hs_s          = out_valid_r && out_ready;
    assign corner_s      = (x_r >= X_EDGE) && (y_r >= Y_EDGE);
    assign corner_last_s = (x_r == X_LAST) && (y_r == Y_LAST);

    // Next-state, position counters and latency countdown.
    always_comb begin
        state_n    = state_r;
        x_n        = x_r;
        y_n        = y_r;
        wait_n     = wait_r;
        last_win_n = last_win_r;
        cap_s      = 1'b0;
        done_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (frame_start) begin
                    state_n    = ST_ACCEPT;
                    x_n        = {XW{1'b0}};
                    y_n        = {YW{1'b0}};
                    last_win_n = 1'b0;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_ACCEPT: begin
                if (xfer_s) begin
                    if (x_r == X_LAST) begin
                        x_n = {XW{1'b0}};
                        if (y_r == Y_LAST) begin
                            y_n = {YW{1'b0}};
                        end else begin
                            y_n = y_r + YW'(1);
                        end
                    end else begin
                        x_n = x_r + XW'(1);
                    end
                    // The accepted pixel is the bottom-right corner of the candidate window.
                    last_win_n = corner_last_s;
                    if (corner_s) begin
                        state_n = ST_LOAD;
                    end else begin
                        state_n = ST_ACCEPT;
                    end
                end else begin
                    state_n = ST_ACCEPT;
                end
            end
            ST_LOAD: begin
                wait_n  = LAT;
                state_n = ST_WAIT;
            end
            ST_WAIT: begin
                // Capture on the edge where the countdown reaches zero.
                if (wait_r <= CW'(1)) begin
                    wait_n  = {CW{1'b0}};
                    cap_s   = 1'b1;
                    state_n = ST_OUTPUT;
                end else begin
                    wait_n  = wait_r - CW'(1);
                    state_n = ST_WAIT;
                end
            end
            ST_OUTPUT: begin
                if (hs_s) begin
                    if (last_win_r) begin
                        done_s  = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_ACCEPT;
                    end
                end else begin
                    state_n = ST_OUTPUT;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Control state and position registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            x_r        <= {XW{1'b0}};
            y_r        <= {YW{1'b0}};
            wait_r     <= {CW{1'b0}};
            last_win_r <= 1'b0;
        end else begin
            state_r    <= state_n;
            x_r        <= x_n;
            y_r        <= y_n;
            wait_r     <= wait_n;
            last_win_r <= last_win_n;
        end
    end

    // Registered handshake and status outputs, decoded from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_ready_r  <= 1'b0;
            conv_load_r  <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            pix_ready_r  <= (state_n == ST_ACCEPT);
            conv_load_r  <= (state_n == ST_LOAD);
            busy_r       <= (state_n != ST_IDLE);
            frame_done_r <= done_s;
        end
    end

    // Output stream register: loaded at capture, held until the handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= 32'd0;
            out_last_r  <= 1'b0;
        end else if (cap_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= post_process(conv_ans);
            out_last_r  <= last_win_r;
        end else if (hs_s) begin
            out_valid_r <= 1'b0;
            out_data_r  <= out_data_r;
            out_last_r  <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
            out_data_r  <= out_data_r;
            out_last_r  <= out_last_r;
        end
    end

    assign pix_ready  = pix_ready_r;
    assign conv_load  = conv_load_r;
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign out_last   = out_last_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

endmodule
